// File: rtl/map_rom_arbiter.sv
// Two-stage arbiter that shares one combinational map font ROM between the video
// pipeline (strict priority, fully pipelined) and the game logic (one read at a time).
module map_rom_arbiter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 800
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic                  vid_valid,
  output logic [DATA_WIDTH-1:0] vid_data,
  input  logic                  game_req,
  input  logic [ADDR_WIDTH-1:0] game_addr,
  output logic                  game_ack,
  output logic [DATA_WIDTH-1:0] game_data,
  output logic                  game_starved,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data
);

  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] LIMIT_W = WAIT_W'(STARVE_LIMIT);
  localparam logic [WAIT_W-1:0] ONE_W   = WAIT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    GNT_VID,
    GNT_GAME
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [ADDR_WIDTH-1:0] r_romAddr;
  logic [ADDR_WIDTH-1:0] w_nextAddr;
  logic                  r_vidValid;
  logic [DATA_WIDTH-1:0] r_vidData;
  logic                  r_gameAck;
  logic [DATA_WIDTH-1:0] r_gameData;
  logic                  r_gameInFlight;
  logic [WAIT_W-1:0]     r_waitCnt;
  logic [WAIT_W-1:0]     w_nextWait;
  logic                  r_starved;
  logic                  w_gameEligible;

  // The wait counter only advances while an eligible game request is losing to video.
  always_comb begin
    w_gameEligible = game_req && !r_gameInFlight && !r_gameAck;
    w_nextState    = IDLE;
    w_nextAddr     = r_romAddr;
    if (vid_req) begin
      w_nextState = GNT_VID;
      w_nextAddr  = vid_addr;
    end else if (w_gameEligible) begin
      w_nextState = GNT_GAME;
      w_nextAddr  = game_addr;
    end

    w_nextWait = r_waitCnt;
    if (!game_req || (w_nextState == GNT_GAME)) begin
      w_nextWait = '0;
    end else if (w_gameEligible && (r_waitCnt != LIMIT_W)) begin
      w_nextWait = r_waitCnt + ONE_W;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state        <= IDLE;
      r_romAddr      <= '0;
      r_vidValid     <= 1'b0;
      r_vidData      <= '0;
      r_gameAck      <= 1'b0;
      r_gameData     <= '0;
      r_gameInFlight <= 1'b0;
      r_waitCnt      <= '0;
      r_starved      <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_romAddr  <= w_nextAddr;
      r_vidValid <= (r_state == GNT_VID);
      r_gameAck  <= (r_state == GNT_GAME);
      if (r_state == GNT_VID) begin
        r_vidData <= rom_data;
      end
      // Stage 2 consumes the row the ROM produced for last cycle's owner.
      if (r_state == GNT_GAME) begin
        r_gameData <= rom_data;
      end
      if (w_nextState == GNT_GAME) begin
        r_gameInFlight <= 1'b1;
      end else if (r_state == GNT_GAME) begin
        r_gameInFlight <= 1'b0;
      end
      r_waitCnt <= w_nextWait;
      r_starved <= (w_nextWait == LIMIT_W);
    end
  end

  assign rom_addr     = r_romAddr;
  assign vid_valid    = r_vidValid;
  assign vid_data     = r_vidData;
  assign game_ack     = r_gameAck;
  assign game_data    = r_gameData;
  assign game_starved = r_starved;

endmodule

// File: tb/tb_map_rom_arbiter.sv
// Self-checking bench for map_rom_arbiter: directed scenarios on the map font ROM
// followed by randomized traffic against a transaction-level reference model.
module tb_map_rom_arbiter;

  localparam int LIMIT = 800;

  logic        Clk;
  logic        Reset;
  logic        vid_req;
  logic [4:0]  vid_addr;
  logic        vid_valid;
  logic [15:0] vid_data;
  logic        game_req;
  logic [4:0]  game_addr;
  logic        game_ack;
  logic [15:0] game_data;
  logic        game_starved;
  logic [4:0]  rom_addr;
  logic [15:0] rom_data;

  logic [15:0] romMem [32];
  int          checks;
  int          failures;

  map_rom_arbiter #(
    .ADDR_WIDTH(5),
    .DATA_WIDTH(16),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .vid_req(vid_req),
    .vid_addr(vid_addr),
    .vid_valid(vid_valid),
    .vid_data(vid_data),
    .game_req(game_req),
    .game_addr(game_addr),
    .game_ack(game_ack),
    .game_data(game_data),
    .game_starved(game_starved),
    .rom_addr(rom_addr),
    .rom_data(rom_data)
  );

  assign rom_data = romMem[rom_addr];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic applyStimulus(input logic rst, input logic vr, input logic [4:0] va,
                               input logic gr, input logic [4:0] ga);
    Reset     = rst;
    vid_req   = vr;
    vid_addr  = va;
    game_req  = gr;
    game_addr = ga;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 1'b1, 5'd7, 1'b1, 5'd9);
    tick();
    checks++; if (vid_valid !== 1'b0) begin failures++; $display("FAIL reset_vid_valid got=%b exp=0", vid_valid); end
    checks++; if (vid_data !== 16'h0000) begin failures++; $display("FAIL reset_vid_data got=%h exp=0000", vid_data); end
    checks++; if (game_ack !== 1'b0) begin failures++; $display("FAIL reset_game_ack got=%b exp=0", game_ack); end
    checks++; if (game_data !== 16'h0000) begin failures++; $display("FAIL reset_game_data got=%h exp=0000", game_data); end
    checks++; if (game_starved !== 1'b0) begin failures++; $display("FAIL reset_starved got=%b exp=0", game_starved); end
    checks++; if (rom_addr !== 5'd0) begin failures++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
    tick();
    checks++; if (vid_valid !== 1'b0) begin failures++; $display("FAIL reset_hold_vid_valid got=%b exp=0", vid_valid); end
    checks++; if (rom_addr !== 5'd0) begin failures++; $display("FAIL reset_hold_rom_addr got=%0d exp=0", rom_addr); end
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    checks++; if (vid_valid !== 1'b0) begin failures++; $display("FAIL reset_ignored_vid got=%b exp=0", vid_valid); end
    checks++; if (game_ack !== 1'b0) begin failures++; $display("FAIL reset_ignored_game got=%b exp=0", game_ack); end
  endtask

  task automatic test_video_stream();
    logic [4:0]  addrs [4] = '{5'd3, 5'd17, 5'd4, 5'd31};
    logic [15:0] datas [4] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
    logic        expValid;
    for (int e = 0; e < 6; e++) begin
      if (e < 4) applyStimulus(1'b0, 1'b1, addrs[e], 1'b0, 5'd0);
      else       applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      tick();
      expValid = (e >= 1) && (e <= 4);
      checks++; if (vid_valid !== expValid) begin failures++; $display("FAIL vid_stream_valid edge%0d got=%b exp=%b", e, vid_valid, expValid); end
      if (expValid) begin
        checks++; if (vid_data !== datas[e-1]) begin failures++; $display("FAIL vid_stream_data edge%0d got=%h exp=%h", e, vid_data, datas[e-1]); end
      end
      if (e < 4) begin
        checks++; if (rom_addr !== addrs[e]) begin failures++; $display("FAIL vid_stream_rom_addr edge%0d got=%0d exp=%0d", e, rom_addr, addrs[e]); end
      end
    end
  endtask

  task automatic test_game_single();
    logic expAck;
    for (int e = 0; e < 5; e++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, (e <= 2), 5'd20);
      tick();
      expAck = (e == 1);
      checks++; if (game_ack !== expAck) begin failures++; $display("FAIL game_single_ack edge%0d got=%b exp=%b", e, game_ack, expAck); end
      if (e == 0) begin
        checks++; if (rom_addr !== 5'd20) begin failures++; $display("FAIL game_single_rom_addr got=%0d exp=20", rom_addr); end
      end
      if (e == 1) begin
        checks++; if (game_data !== 16'hFFFF) begin failures++; $display("FAIL game_single_data got=%h exp=FFFF", game_data); end
      end
    end
  endtask

  task automatic test_priority();
    logic expValid;
    logic expAck;
    for (int e = 0; e < 6; e++) begin
      applyStimulus(1'b0, (e < 3), 5'd9, (e <= 4), 5'd2);
      tick();
      expValid = (e >= 1) && (e <= 3);
      expAck   = (e == 4);
      checks++; if (vid_valid !== expValid) begin failures++; $display("FAIL priority_vid_valid edge%0d got=%b exp=%b", e, vid_valid, expValid); end
      checks++; if (game_ack !== expAck) begin failures++; $display("FAIL priority_game_ack edge%0d got=%b exp=%b", e, game_ack, expAck); end
      if (expAck) begin
        checks++; if (game_data !== 16'h0000) begin failures++; $display("FAIL priority_game_data got=%h exp=0000", game_data); end
      end
    end
  endtask

  task automatic test_starvation();
    logic expStarved;
    applyStimulus(1'b0, 1'b1, 5'd31, 1'b1, 5'd20);
    for (int i = 1; i <= 900; i++) begin
      tick();
      expStarved = (i >= LIMIT);
      checks++; if (game_starved !== expStarved) begin failures++; $display("FAIL starve_flag wait%0d got=%b exp=%b", i, game_starved, expStarved); end
      checks++; if (game_ack !== 1'b0) begin failures++; $display("FAIL starve_no_ack wait%0d got=%b exp=0", i, game_ack); end
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 5'd20);
    tick();
    checks++; if (game_starved !== 1'b0) begin failures++; $display("FAIL starve_clear got=%b exp=0", game_starved); end
    checks++; if (rom_addr !== 5'd20) begin failures++; $display("FAIL starve_grant_addr got=%0d exp=20", rom_addr); end
    checks++; if (game_ack !== 1'b0) begin failures++; $display("FAIL starve_early_ack got=%b exp=0", game_ack); end
    tick();
    checks++; if (game_ack !== 1'b1) begin failures++; $display("FAIL starve_ack got=%b exp=1", game_ack); end
    checks++; if (game_data !== 16'hFFFF) begin failures++; $display("FAIL starve_data got=%h exp=FFFF", game_data); end
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    tick();
  endtask

  task automatic test_reset_midflight();
    applyStimulus(1'b0, 1'b1, 5'd31, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    checks++; if (vid_valid !== 1'b0) begin failures++; $display("FAIL midreset_vid_valid got=%b exp=0", vid_valid); end
    checks++; if (vid_data !== 16'h0000) begin failures++; $display("FAIL midreset_vid_data got=%h exp=0000", vid_data); end
    checks++; if (game_data !== 16'h0000) begin failures++; $display("FAIL midreset_game_data got=%h exp=0000", game_data); end
    checks++; if (rom_addr !== 5'd0) begin failures++; $display("FAIL midreset_rom_addr got=%0d exp=0", rom_addr); end
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    checks++; if (vid_valid !== 1'b0) begin failures++; $display("FAIL midreset_vid_dropped got=%b exp=0", vid_valid); end
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 5'd20);
    tick();
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd20);
    tick();
    checks++; if (game_ack !== 1'b0) begin failures++; $display("FAIL midreset_game_ack got=%b exp=0", game_ack); end
    checks++; if (rom_addr !== 5'd0) begin failures++; $display("FAIL midreset_game_rom_addr got=%0d exp=0", rom_addr); end
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 5'd20);
    tick();
    checks++; if (game_ack !== 1'b0) begin failures++; $display("FAIL resume_game_early got=%b exp=0", game_ack); end
    checks++; if (rom_addr !== 5'd20) begin failures++; $display("FAIL resume_game_addr got=%0d exp=20", rom_addr); end
    tick();
    checks++; if (game_ack !== 1'b1) begin failures++; $display("FAIL resume_game_ack got=%b exp=1", game_ack); end
    checks++; if (game_data !== 16'hFFFF) begin failures++; $display("FAIL resume_game_data got=%h exp=FFFF", game_data); end
    applyStimulus(1'b0, 1'b1, 5'd18, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    checks++; if (vid_valid !== 1'b1) begin failures++; $display("FAIL resume_vid_valid got=%b exp=1", vid_valid); end
    checks++; if (vid_data !== 16'hFFFF) begin failures++; $display("FAIL resume_vid_data got=%h exp=FFFF", vid_data); end
  endtask

  task automatic test_random();
    logic        rst, vr, gReq, dropNext, eligible, gameGrant;
    logic [4:0]  va, gAddr;
    logic        mVidPend, mGamePend;
    logic [4:0]  mVidAddr, mGameAddr;
    logic        expVidValid, expGameAck, expStarved;
    logic [15:0] expVidData, expGameData;
    logic [4:0]  expRomAddr;
    int          mWait;
    for (int i = 0; i < 32; i++) romMem[i] = 16'($urandom);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    mVidPend = 0; mGamePend = 0; mVidAddr = 0; mGameAddr = 0; mWait = 0;
    expVidValid = 0; expGameAck = 0; expStarved = 0;
    expVidData = 0; expGameData = 0; expRomAddr = 0;
    gReq = 0; gAddr = 0; dropNext = 0;
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(99) == 0);
      vr  = ($urandom_range(9) < 6);
      va  = 5'($urandom_range(31));
      if (gReq && dropNext) begin
        gReq = 0; dropNext = 0;
      end else if (gReq && expGameAck) begin
        if ($urandom_range(1) == 1) gReq = 0;
        else dropNext = 1;
      end else if (!gReq && ($urandom_range(3) == 0)) begin
        gReq = 1; gAddr = 5'($urandom_range(31));
      end
      applyStimulus(rst, vr, va, gReq, gAddr);

      // Transaction-level expectation of what the coming edge makes visible.
      if (rst) begin
        mVidPend = 0; mGamePend = 0; mWait = 0;
        expVidValid = 0; expGameAck = 0; expStarved = 0;
        expVidData = 0; expGameData = 0; expRomAddr = 0;
      end else begin
        eligible  = gReq && !mGamePend && !expGameAck;
        gameGrant = !vr && eligible;
        expVidValid = mVidPend;
        if (mVidPend) expVidData = romMem[mVidAddr];
        expGameAck = mGamePend;
        if (mGamePend) expGameData = romMem[mGameAddr];
        if (vr) expRomAddr = va;
        else if (gameGrant) expRomAddr = gAddr;
        mVidPend = vr; mVidAddr = va;
        mGamePend = gameGrant; mGameAddr = gAddr;
        if (!gReq || gameGrant) mWait = 0;
        else if (eligible && mWait < LIMIT) mWait++;
        expStarved = (mWait == LIMIT);
      end
      tick();

      checks++; if (vid_valid !== expVidValid) begin failures++; $display("FAIL rand_vid_valid cyc%0d got=%b exp=%b", c, vid_valid, expVidValid); end
      checks++; if (vid_data !== expVidData) begin failures++; $display("FAIL rand_vid_data cyc%0d got=%h exp=%h", c, vid_data, expVidData); end
      checks++; if (game_ack !== expGameAck) begin failures++; $display("FAIL rand_game_ack cyc%0d got=%b exp=%b", c, game_ack, expGameAck); end
      checks++; if (game_data !== expGameData) begin failures++; $display("FAIL rand_game_data cyc%0d got=%h exp=%h", c, game_data, expGameData); end
      checks++; if (rom_addr !== expRomAddr) begin failures++; $display("FAIL rand_rom_addr cyc%0d got=%0d exp=%0d", c, rom_addr, expRomAddr); end
      checks++; if (game_starved !== expStarved) begin failures++; $display("FAIL rand_starved cyc%0d got=%b exp=%b", c, game_starved, expStarved); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) romMem[i] = (i < 16) ? 16'h0000 : 16'hFFFF;
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
    test_reset();
    test_video_stream();
    test_game_single();
    test_priority();
    test_starvation();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/map_rom_arbiter.md
MAP_ROM_ARBITER -- requirements
Module: map_rom_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 5, meaning ROM address width ({tile type bit, 4-bit row}).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, meaning ROM row width in pixels.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 800, meaning wait cycles (one 800-clock scanline) before the game requester is flagged starved.
REQ-004 Clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 vid_req  input  1  video pipeline requests one ROM row this cycle.
REQ-007 vid_addr  input  ADDR_WIDTH  ROM address for the video request.
REQ-008 vid_valid  output  1  one-cycle pulse: vid_data holds a video read result.
REQ-009 vid_data  output  DATA_WIDTH  registered ROM row returned to video.
REQ-010 game_req  input  1  game-logic (wall collision) read request, level, held until game_ack.
REQ-011 game_addr  input  ADDR_WIDTH  ROM address for the game request, stable while game_req=1.
REQ-012 game_ack  output  1  one-cycle pulse: game_data holds the game read result.
REQ-013 game_data  output  DATA_WIDTH  registered ROM row returned to game logic.
REQ-014 game_starved  output  1  pending game request has waited STARVE_LIMIT cycles.
REQ-015 rom_addr  output  ADDR_WIDTH  registered address to the combinational map font ROM.
REQ-016 rom_data  input  DATA_WIDTH  ROM row for rom_addr, same cycle.

Function
REQ-017 Stage-1 FSM SHALL have states IDLE, GNT_VID, GNT_GAME naming the owner of rom_addr for the current cycle.
REQ-018 Each edge: vid_req=1 -> GNT_VID, rom_addr<=vid_addr; else eligible game request -> GNT_GAME, rom_addr<=game_addr; else IDLE, rom_addr held.
REQ-019 Video SHALL have strict priority; simultaneous vid_req and game_req grant video.
REQ-020 Game request SHALL be eligible only when game_req=1, no game read is in flight (granted, not yet acked), and game_ack is not high this cycle.
REQ-021 Stage 2: edge after a grant SHALL capture rom_data into vid_data or game_data (per owner) and pulse vid_valid or game_ack high for exactly one cycle.
REQ-022 Latency SHALL be 2 cycles: request sampled at edge N -> valid/ack high in the cycle after edge N+1.
REQ-023 Video SHALL be fully pipelined: vid_req every cycle yields vid_valid every cycle, in order, no bubbles.
REQ-024 At most one game read SHALL be in flight; requester drops or changes game_req only after game_ack.
REQ-025 vid_data/game_data SHALL hold last captured value when not updated.
REQ-026 Wait counter (clog2(STARVE_LIMIT+1) bits) SHALL increment each cycle game_req=1 and game not granted and none in flight; saturate at STARVE_LIMIT; clear to 0 on game grant or game_req=0.
REQ-027 game_starved SHALL be 1 exactly when wait counter == STARVE_LIMIT (registered); no forced grant -- video priority is never violated.
REQ-028 Unused ROM bits/addresses SHALL be passed through unaltered; no address range check.

Reset
REQ-029 Reset=1 at an edge SHALL set FSM=IDLE, rom_addr=0, vid_data=0, game_data=0, vid_valid=0, game_ack=0, in-flight flag=0, wait counter=0, game_starved=0.
REQ-030 Reset mid-transaction SHALL drop all in-flight reads: no vid_valid or game_ack for requests sampled before or during reset.
REQ-031 Requests SHALL be ignored while Reset=1; first grant possible at the first edge with Reset=0.

Verification (map font ROM attached: addr 0-15 -> 16'h0000, 16-31 -> 16'hFFFF)
REQ-032 vid_req=1 for 4 cycles, vid_addr=3,17,4,31 -> vid_valid high 4 consecutive cycles starting 2 cycles later, vid_data=0000,FFFF,0000,FFFF.
REQ-033 game_req=1, game_addr=20, vid_req=0 -> game_ack single pulse 2 cycles later, game_data=FFFF; game_req held one more cycle -> no second ack.
REQ-034 vid_req and game_req (addr 2) rise together, vid_req high 3 cycles -> 3 vid_valid pulses first, game_ack after, game_data=0000.
REQ-035 vid_req=1 continuously 900 cycles with game_req=1 -> game_starved=1 from wait cycle 800 on, no game_ack; vid_req drops -> game granted, game_starved=0 next cycle, ack 2 cycles after grant.
REQ-036 Reset=1 for one cycle immediately after granting a video and a game read -> no vid_valid/game_ack, all outputs 0 next cycle, normal 2-cycle operation resumes.
